// File: rtl/i2c_rd_arbiter_if.sv
// Bus bundle between the two-requester I2C read arbiter, its requesters and the byte receiver.
interface i2c_rd_arbiter_if;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic [1:0] gnt;
  logic       rx_ready;
  logic [3:0] rx_data_bytes;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_id;
  logic       done;
  logic       err;

  modport slave (
    input  req, len0, len1, rx_data, rx_data_valid,
    output gnt, rx_ready, rx_data_bytes, out_data, out_valid, out_last, out_id, done, err
  );

  modport master (
    output req, len0, len1, rx_data, rx_data_valid,
    input  gnt, rx_ready, rx_data_bytes, out_data, out_valid, out_last, out_id, done, err
  );
endinterface

// File: rtl/i2c_rd_arbiter.sv
// Round-robin arbiter granting one of two requesters a multi-byte I2C read.
// Optional watchdog on the WAIT state is compiled in with I2C_RD_ARBITER_TIMEOUT_EN.
module i2c_rd_arbiter #(
  parameter int unsigned GAP_CYC     = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input logic             clk,
  input logic             rst_n,
  i2c_rd_arbiter_if.slave bus
);
  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_gnt, w_gnt;
  logic             r_id, w_id;
  logic [3:0]       r_bytes, w_bytes;
  logic [3:0]       r_cnt, w_cnt;
  logic [GAP_W-1:0] r_gap, w_gap;
  logic             r_rdy, w_rdy;
  logic [7:0]       r_data, w_data;
  logic             r_valid, w_valid;
  logic             r_out_last, w_out_last;
  logic             r_done, w_done;
  logic             r_last_gnt, w_last_gnt;
  logic             r_rxv_q;

  logic             w_pick;
  logic [3:0]       w_pick_len;
  logic             w_byte;
  logic             w_final;
  logic             w_gap_end;
  logic             w_timeout;

  // r_last_gnt holds the index granted last; reset to 1 so requester 0 wins the first tie.
  assign w_pick     = (bus.req == 2'b11) ? ~r_last_gnt : bus.req[1];
  assign w_pick_len = w_pick ? bus.len1 : bus.len0;
  assign w_byte     = (r_state == S_WAIT) && bus.rx_data_valid && !r_rxv_q;
  assign w_final    = w_byte && ((r_cnt + 4'd1) == r_bytes);
  assign w_gap_end  = (r_gap == GAP_W'(GAP_CYC - 1));

`ifdef I2C_RD_ARBITER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wd, w_wd;
  logic            r_err, w_err;

  assign w_timeout = (r_state == S_WAIT) && !w_byte && (r_wd == WD_W'(TIMEOUT_CYC - 1));
  assign bus.err   = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus.err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.req != 2'b00) w_next = (w_pick_len == 4'd0) ? S_DONE : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (w_final)        w_next = S_DONE;
        else if (w_timeout) w_next = S_GAP;
      end
      S_DONE:  w_next = S_GAP;
      S_GAP:   if (w_gap_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_gnt      = r_gnt;
    w_id       = r_id;
    w_bytes    = r_bytes;
    w_cnt      = r_cnt;
    w_gap      = r_gap;
    w_rdy      = 1'b0;
    w_data     = r_data;
    w_valid    = 1'b0;
    w_out_last = 1'b0;
    w_done     = 1'b0;
    w_last_gnt = r_last_gnt;
`ifdef I2C_RD_ARBITER_TIMEOUT_EN
    w_wd       = r_wd;
    w_err      = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          w_gnt      = w_pick ? 2'b10 : 2'b01;
          w_id       = w_pick;
          w_bytes    = w_pick_len;
          w_cnt      = '0;
          w_last_gnt = w_pick;
        end
      end
      S_ISSUE: begin
        w_rdy = 1'b1;
`ifdef I2C_RD_ARBITER_TIMEOUT_EN
        w_wd  = '0;
`endif
      end
      S_WAIT: begin
`ifdef I2C_RD_ARBITER_TIMEOUT_EN
        w_wd = r_wd + 1'b1;
`endif
        if (w_byte) begin
          w_data     = bus.rx_data;
          w_valid    = 1'b1;
          w_cnt      = r_cnt + 4'd1;
          w_out_last = w_final;
`ifdef I2C_RD_ARBITER_TIMEOUT_EN
          w_wd       = '0;
`endif
        end else if (w_timeout) begin
          w_done = 1'b1;
          w_gnt  = '0;
          w_gap  = '0;
`ifdef I2C_RD_ARBITER_TIMEOUT_EN
          w_err  = 1'b1;
`endif
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_gnt  = '0;
        w_gap  = '0;
      end
      S_GAP:   w_gap = r_gap + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt      <= '0;
      r_id       <= 1'b0;
      r_bytes    <= '0;
      r_cnt      <= '0;
      r_gap      <= '0;
      r_rdy      <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_out_last <= 1'b0;
      r_done     <= 1'b0;
      r_last_gnt <= 1'b1;
      r_rxv_q    <= 1'b0;
`ifdef I2C_RD_ARBITER_TIMEOUT_EN
      r_wd       <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_gnt      <= w_gnt;
      r_id       <= w_id;
      r_bytes    <= w_bytes;
      r_cnt      <= w_cnt;
      r_gap      <= w_gap;
      r_rdy      <= w_rdy;
      r_data     <= w_data;
      r_valid    <= w_valid;
      r_out_last <= w_out_last;
      r_done     <= w_done;
      r_last_gnt <= w_last_gnt;
      r_rxv_q    <= bus.rx_data_valid;
`ifdef I2C_RD_ARBITER_TIMEOUT_EN
      r_wd       <= w_wd;
      r_err      <= w_err;
`endif
    end
  end

  assign bus.gnt           = r_gnt;
  assign bus.rx_ready      = r_rdy;
  assign bus.rx_data_bytes = r_bytes;
  assign bus.out_data      = r_data;
  assign bus.out_valid     = r_valid;
  assign bus.out_last      = r_out_last;
  assign bus.out_id        = r_id;
  assign bus.done          = r_done;
endmodule

// File: tb/tb_i2c_rd_arbiter.sv
// Directed bench for i2c_rd_arbiter; output bytes are checked against a scoreboard queue.
module tb_i2c_rd_arbiter;
  localparam int unsigned GAP = 16;
  localparam int unsigned TMO = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2c_rd_arbiter_if bus ();

  i2c_rd_arbiter #(.GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned n_rdy = 0, n_done = 0, n_err = 0, n_valid = 0;
  int unsigned zero_run = 0, last_idle = 0;
  logic [1:0]  prev_gnt = '0;
  logic [9:0]  sb[$];
  logic [9:0]  exp_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pulse counters, idle-run length before each grant, scoreboard pops.
  always @(negedge clk) begin
    if (bus.rx_ready) n_rdy++;
    if (bus.done)     n_done++;
    if (bus.err)      n_err++;
    if (bus.gnt == 2'b00) zero_run++;
    else begin
      if (prev_gnt == 2'b00) last_idle = zero_run;
      zero_run = 0;
    end
    prev_gnt = bus.gnt;
    if (bus.out_valid) begin
      n_valid++;
      check("out_valid_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_e = sb.pop_front();
        check("out_data_last_id", 32'({bus.out_data, bus.out_last, bus.out_id}), 32'(exp_e));
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.len0 = '0; bus.len1 = '0;
    bus.rx_data = '0; bus.rx_data_valid = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic wait_rdy(input string tag);
    int unsigned k = 0;
    smp();
    while (!bus.rx_ready && k < 40) begin smp(); k++; end
    check(tag, 32'(bus.rx_ready), 1);
  endtask

  task automatic wait_gnt(input string tag);
    int unsigned k = 0;
    smp();
    while (bus.gnt == 2'b00 && k < 60) begin smp(); k++; end
    check(tag, 32'(bus.gnt != 2'b00), 1);
  endtask

  task automatic wait_done(input int unsigned target, input string tag);
    int unsigned k = 0;
    while (n_done < target && k < 200) begin smp(); k++; end
    check(tag, 32'(n_done >= target), 1);
  endtask

  task automatic send_byte(input logic [7:0] d, input int unsigned hold, input logic last, input logic id);
    sb.push_back({d, last, id});
    bus.rx_data = d;
    bus.rx_data_valid = 1'b1;
    step(hold);
    bus.rx_data_valid = 1'b0;
    step(2);
  endtask

  initial begin
    int unsigned b_rdy, b_done, b_err, b_valid, k;
    logic [1:0] g_exp;

    // Reset values
    rst_n = 1'b0;
    bus.req = '0; bus.len0 = '0; bus.len1 = '0;
    bus.rx_data = '0; bus.rx_data_valid = 1'b0;
    step(3);
    smp();
    check("reset_outputs", 32'({bus.gnt, bus.rx_ready, bus.rx_data_bytes, bus.out_data, bus.out_valid,
                               bus.out_last, bus.out_id, bus.done, bus.err}), 0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // Three-byte read for requester 0, with req dropped and len changed after grant
    b_rdy = n_rdy; b_done = n_done; b_err = n_err; b_valid = n_valid;
    bus.len0 = 4'd3; bus.req = 2'b01;
    step(1);
    smp();
    check("grant_gnt", 32'(bus.gnt), 32'h1);
    check("grant_bytes", 32'(bus.rx_data_bytes), 3);
    check("grant_no_rdy_yet", 32'(bus.rx_ready), 0);
    smp();
    check("rdy_timing", 32'(bus.rx_ready), 1);
    bus.req = 2'b00; bus.len0 = 4'd7;
    send_byte(8'hA5, 1, 1'b0, 1'b0);
    check("gnt_held_b1", 32'(bus.gnt), 32'h1);
    send_byte(8'h3C, 1, 1'b0, 1'b0);
    check("gnt_held_b2", 32'(bus.gnt), 32'h1);
    check("bytes_unchanged", 32'(bus.rx_data_bytes), 3);
    send_byte(8'hFF, 1, 1'b1, 1'b0);
    wait_done(b_done + 1, "t1_done");
    check("t1_rdy_count", n_rdy - b_rdy, 1);
    check("t1_valid_count", n_valid - b_valid, 3);
    check("t1_done_count", n_done - b_done, 1);
    check("t1_err_count", n_err - b_err, 0);
    check("t1_gnt_cleared", 32'(bus.gnt), 0);

    // Round-robin with both requesting, from a fresh reset
    do_reset();
    bus.len0 = 4'd1; bus.len1 = 4'd1; bus.req = 2'b11;
    for (int unsigned i = 0; i < 3; i++) begin
      g_exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_gnt("rr_grant_seen");
      check("rr_gnt", 32'(bus.gnt), 32'(g_exp));
      check("rr_out_id", 32'(bus.out_id), 32'(g_exp[1]));
      if (i > 0) check("rr_idle_gap", 32'(last_idle >= GAP + 1), 1);
      wait_rdy("rr_rdy");
      b_done = n_done;
      send_byte(8'h10 + 8'(i), 1, 1'b1, g_exp[1]);
      wait_done(b_done + 1, "rr_done");
    end
    bus.req = 2'b00;
    step(GAP + 4);

    // Zero-length read, then a receiver pulse outside WAIT
    b_rdy = n_rdy; b_done = n_done; b_valid = n_valid;
    bus.len1 = 4'd0; bus.req = 2'b10;
    wait_gnt("z_grant_seen");
    check("z_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 2'b00;
    wait_done(b_done + 1, "z_done");
    check("z_no_rdy", n_rdy - b_rdy, 0);
    check("z_no_valid", n_valid - b_valid, 0);
    bus.rx_data = 8'h99; bus.rx_data_valid = 1'b1;
    step(1);
    bus.rx_data_valid = 1'b0;
    step(3);
    check("gap_edge_ignored", n_valid - b_valid, 0);
    step(GAP + 4);

    // Held-high valid counts as one byte
    b_done = n_done; b_valid = n_valid;
    bus.len0 = 4'd2; bus.req = 2'b01;
    wait_rdy("hold_rdy");
    bus.req = 2'b00;
    send_byte(8'hA1, 5, 1'b0, 1'b0);
    step(3);
    check("hold_one_valid", n_valid - b_valid, 1);
    check("hold_still_granted", 32'(bus.gnt), 32'h1);
    check("hold_no_done", n_done - b_done, 0);
    send_byte(8'h5A, 1, 1'b1, 1'b0);
    wait_done(b_done + 1, "hold_done");
    step(GAP + 4);

    // No bytes arrive
    b_done = n_done; b_err = n_err; b_valid = n_valid;
    bus.len0 = 4'd1; bus.req = 2'b01;
    wait_rdy("tmo_rdy");
    bus.req = 2'b00;
`ifdef I2C_RD_ARBITER_TIMEOUT_EN
    k = 0;
    while (!bus.err && k < TMO + 10) begin smp(); k++; end
    check("tmo_err", 32'(bus.err), 1);
    check("tmo_done_with_err", 32'(bus.done), 1);
    check("tmo_latency", k, TMO);
    check("tmo_gnt_cleared", 32'(bus.gnt), 0);
    check("tmo_no_out_valid", n_valid - b_valid, 0);
`else
    k = 0;
    step(TMO + 20);
    check("nowd_err_count", n_err - b_err, 0);
    check("nowd_no_done", n_done - b_done, 0);
    check("nowd_still_granted", 32'(bus.gnt), 32'h1);
    send_byte(8'hC3, 1, 1'b1, 1'b0);
    wait_done(b_done + 1, "nowd_done");
`endif
    step(GAP + 4);

    // Reset in WAIT after one of three bytes, then a fresh read
    bus.len0 = 4'd3; bus.req = 2'b01;
    wait_rdy("rst_rdy");
    bus.req = 2'b00;
    send_byte(8'hA5, 1, 1'b0, 1'b0);
    b_done = n_done; b_err = n_err;
    rst_n = 1'b0;
    #2;
    check("midrst_outputs_async", 32'({bus.gnt, bus.rx_ready, bus.rx_data_bytes, bus.out_data, bus.out_valid,
                                      bus.out_last, bus.out_id, bus.done, bus.err}), 0);
    smp();
    check("midrst_outputs", 32'({bus.gnt, bus.rx_ready, bus.rx_data_bytes, bus.out_data, bus.out_valid,
                                bus.out_last, bus.out_id, bus.done, bus.err}), 0);
    check("midrst_no_done", n_done - b_done, 0);
    check("midrst_no_err", n_err - b_err, 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    bus.len0 = 4'd1; bus.req = 2'b01;
    wait_gnt("post_rst_grant_seen");
    check("post_rst_gnt", 32'(bus.gnt), 32'h1);
    wait_rdy("post_rst_rdy");
    bus.req = 2'b00;
    send_byte(8'h77, 1, 1'b1, 1'b0);
    wait_done(b_done + 1, "post_rst_done");
    step(2);
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
